// File: rtl/nanov_pkg.sv
// Shared state encodings and flash read commands for the nanov SPI instruction fetch unit.
package nanov_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_DESEL = 3'd0;
  localparam state_t ST_CMD   = 3'd1;
  localparam state_t ST_ADDR  = 3'd2;
  localparam state_t ST_DUMMY = 3'd3;
  localparam state_t ST_DATA  = 3'd4;
  localparam state_t ST_PAUSE = 3'd5;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

endpackage

// File: rtl/nanov_fetch_fifo.sv
// Prefetch FIFO of instruction words with their flash addresses; head visible the cycle after push.
// Push and pop may coincide when full; flush empties it in one cycle and overrides push/pop.
module nanov_fetch_fifo #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 24
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic                         push,
  input  logic [31:0]                  push_data,
  input  logic [ADDR_W-1:0]            push_pc,
  input  logic                         pop,
  output logic                         valid,
  output logic [31:0]                  head_data,
  output logic [ADDR_W-1:0]            head_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]       mem_data [DEPTH];
  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;

  assign valid     = (count != '0);
  assign head_data = mem_data[rd_ptr];
  assign head_pc   = mem_pc[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_data[wr_ptr] <= push_data;
      mem_pc[wr_ptr]   <= push_pc;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/nanov_spi_fetch.sv
// SPI flash instruction prefetcher; first word valid 8+ADDR_W+32 cycles after select falls (+8 with NANOV_FETCH_FAST_READ_EN).
// Gates the flash clock (select held low) whenever the FIFO could not absorb another word.
module nanov_spi_fetch
  import nanov_pkg::*;
#(
  parameter int                ADDR_W     = 24,
  parameter int                DEPTH      = 2,
  parameter int                CS_HIGH    = 2,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              spi_data_in,
  output logic              spi_select,
  output logic              spi_out,
  output logic              spi_clk_en,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_addr
);

`ifdef NANOV_FETCH_FAST_READ_EN
  localparam logic [7:0] CMD_BYTE  = CMD_FAST_READ;
  localparam bit         USE_DUMMY = 1'b1;
`else
  localparam logic [7:0] CMD_BYTE  = CMD_READ;
  localparam bit         USE_DUMMY = 1'b0;
`endif
  localparam int CNT_W = $clog2(DEPTH + 1);

  state_t            state, state_nx;
  logic [7:0]        cnt, cnt_nx;
  logic [ADDR_W-1:0] fetch_addr, addr_bits;
  logic [30:0]       shreg;
  logic [31:0]       word;
  logic [7:0]        cmd_bits;
  logic [CNT_W-1:0]  fifo_count;
  logic              push, pop, last_bit, out_nx, clk_en_nx;
  int                occ_after;

  assign pop       = instr_valid && instr_ready;
  assign last_bit  = (state == ST_DATA) && (cnt == 8'd31);
  assign push      = last_bit && !branch_valid;
  assign word      = {spi_data_in, shreg};
  // Occupancy once this edge's push/pop settle; the next word needs one more free slot.
  assign occ_after = int'(fifo_count) + 1 - (pop ? 1 : 0);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 8'd1;
    if (branch_valid) begin
      state_nx = ST_DESEL;
      cnt_nx   = '0;
    end else begin
      case (state)
        ST_DESEL: if (cnt == 8'(CS_HIGH - 1)) begin
          state_nx = ST_CMD;
          cnt_nx   = '0;
        end
        ST_CMD: if (cnt == 8'd7) begin
          state_nx = ST_ADDR;
          cnt_nx   = '0;
        end
        ST_ADDR: if (cnt == 8'(ADDR_W - 1)) begin
          state_nx = USE_DUMMY ? ST_DUMMY : ST_DATA;
          cnt_nx   = '0;
        end
        ST_DUMMY: if (cnt == 8'd7) begin
          state_nx = ST_DATA;
          cnt_nx   = '0;
        end
        ST_DATA: if (last_bit) begin
          cnt_nx = '0;
          if (occ_after >= DEPTH) state_nx = ST_PAUSE;
        end
        ST_PAUSE: begin
          cnt_nx = '0;
          if (pop) state_nx = ST_DATA;
        end
        default: begin
          state_nx = ST_DESEL;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Pin values are computed from the next state so they register in step with it.
  always_comb begin
    cmd_bits  = CMD_BYTE << cnt_nx[2:0];
    addr_bits = fetch_addr << cnt_nx;
    out_nx    = 1'b0;
    clk_en_nx = 1'b0;
    case (state_nx)
      ST_CMD: begin
        out_nx    = cmd_bits[7];
        clk_en_nx = 1'b1;
      end
      ST_ADDR: begin
        out_nx    = addr_bits[ADDR_W-1];
        clk_en_nx = 1'b1;
      end
      ST_DUMMY, ST_DATA: clk_en_nx = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_DESEL;
      cnt        <= '0;
      fetch_addr <= RESET_ADDR;
      shreg      <= '0;
      spi_select <= 1'b1;
      spi_out    <= 1'b0;
      spi_clk_en <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      spi_select <= (state_nx == ST_DESEL);
      spi_out    <= out_nx;
      spi_clk_en <= clk_en_nx;
      if (branch_valid) begin
        fetch_addr <= branch_addr & ~ADDR_W'(3);
        shreg      <= '0;
      end else begin
        if (state == ST_DATA) shreg <= word[31:1];
        if (push) fetch_addr <= fetch_addr + ADDR_W'(4);
      end
    end
  end

  nanov_fetch_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (branch_valid),
    .push      (push),
    .push_data (word),
    .push_pc   (fetch_addr),
    .pop       (pop),
    .valid     (instr_valid),
    .head_data (instr_data),
    .head_pc   (instr_pc),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_nanov_spi_fetch.sv
// Directed bench for nanov_spi_fetch with a behavioural serial flash model.
module tb_nanov_spi_fetch;

`ifdef NANOV_FETCH_FAST_READ_EN
  localparam logic [7:0] EXP_CMD = 8'h0B;
  localparam int         DSTART  = 40;
`else
  localparam logic [7:0] EXP_CMD = 8'h03;
  localparam int         DSTART  = 32;
`endif
  localparam int LAT = DSTART + 34;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        spi_data_in = 1'b0;
  logic        spi_select, spi_out, spi_clk_en, instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [23:0] instr_pc;
  logic        branch_valid = 1'b0;
  logic [23:0] branch_addr = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  nanov_spi_fetch dut (
    .clk          (clk),
    .rstn         (rstn),
    .spi_data_in  (spi_data_in),
    .spi_select   (spi_select),
    .spi_out      (spi_out),
    .spi_clk_en   (spi_clk_en),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_data   (instr_data),
    .instr_pc     (instr_pc),
    .branch_valid (branch_valid),
    .branch_addr  (branch_addr)
  );

  function automatic logic [31:0] flash_word(input logic [23:0] a);
    if (a == 24'h0) return 32'h00500093;
    return {8'hA5, a};
  endfunction

  // Flash model: counts clocked cycles since select fell, captures command/address, returns data LSB first.
  int          nb = 0;
  int          b;
  logic [7:0]  cap_cmd = '0;
  logic [23:0] cap_addr = '0;
  logic [31:0] fw;
  always @(negedge clk) begin
    if (!rstn || spi_select) begin
      nb = 0;
      cap_cmd = '0;
      cap_addr = '0;
      spi_data_in = 1'b0;
    end else if (spi_clk_en) begin
      if (nb < 8) cap_cmd = {cap_cmd[6:0], spi_out};
      else if (nb < 32) cap_addr = {cap_addr[22:0], spi_out};
      else if (nb >= DSTART) begin
        b = nb - DSTART;
        fw = flash_word(cap_addr + 24'(4 * (b / 32)));
        spi_data_in = fw[b % 32];
      end
      nb = nb + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    cyc += n;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic apply_reset;
    rstn = 1'b0;
    instr_ready = 1'b0;
    branch_valid = 1'b0;
    branch_addr = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (spi_select !== 1'b1) begin errors++; $display("FAIL rst_select got %b exp 1", spi_select); end
    checks++; if (spi_out !== 1'b0) begin errors++; $display("FAIL rst_out got %b exp 0", spi_out); end
    checks++; if (spi_clk_en !== 1'b0) begin errors++; $display("FAIL rst_clk_en got %b exp 0", spi_clk_en); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
    rstn = 1'b1;
    cyc = 0;
  endtask

  task automatic test_basic;
    wait_until(1);
    checks++; if (spi_select !== 1'b1) begin errors++; $display("FAIL basic_sel_c1 got %b exp 1", spi_select); end
    wait_until(2);
    checks++; if (spi_select !== 1'b0) begin errors++; $display("FAIL basic_sel_c2 got %b exp 0", spi_select); end
    checks++; if (spi_clk_en !== 1'b1) begin errors++; $display("FAIL basic_clk_en_c2 got %b exp 1", spi_clk_en); end
`ifdef NANOV_FETCH_FAST_READ_EN
    wait_until(36);
    checks++; if ({spi_clk_en, spi_out} !== 2'b10) begin errors++; $display("FAIL dummy_pins got %b exp 10", {spi_clk_en, spi_out}); end
`endif
    wait_until(40);
    checks++; if (cap_cmd !== EXP_CMD) begin errors++; $display("FAIL basic_cmd got %h exp %h", cap_cmd, EXP_CMD); end
    checks++; if (cap_addr !== 24'h000000) begin errors++; $display("FAIL basic_addr got %h exp 000000", cap_addr); end
    wait_until(LAT - 1);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", instr_valid); end
    wait_until(LAT);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", instr_valid); end
    checks++; if (instr_data !== 32'h00500093) begin errors++; $display("FAIL basic_data got %h exp 00500093", instr_data); end
    checks++; if (instr_pc !== 24'h000000) begin errors++; $display("FAIL basic_pc got %h exp 000000", instr_pc); end
  endtask

  task automatic test_pause;
    wait_until(LAT + 34);
    checks++; if ({spi_select, spi_clk_en} !== 2'b00) begin errors++; $display("FAIL pause_pins got %b exp 00", {spi_select, spi_clk_en}); end
    checks++; if (instr_pc !== 24'h000000) begin errors++; $display("FAIL pause_head_pc got %h exp 000000", instr_pc); end
    instr_ready = 1'b1;
    tick(1);
    instr_ready = 1'b0;
    checks++; if (spi_clk_en !== 1'b1) begin errors++; $display("FAIL resume_clk_en got %b exp 1", spi_clk_en); end
    checks++; if (instr_pc !== 24'h000004) begin errors++; $display("FAIL pop1_pc got %h exp 000004", instr_pc); end
    checks++; if (instr_data !== flash_word(24'h4)) begin errors++; $display("FAIL pop1_data got %h exp %h", instr_data, flash_word(24'h4)); end
    wait_until(LAT + 68);
    checks++; if ({spi_select, spi_clk_en} !== 2'b00) begin errors++; $display("FAIL repause_pins got %b exp 00", {spi_select, spi_clk_en}); end
    instr_ready = 1'b1;
    tick(1);
    instr_ready = 1'b0;
    checks++; if (instr_pc !== 24'h000008) begin errors++; $display("FAIL pop2_pc got %h exp 000008", instr_pc); end
    checks++; if (instr_data !== flash_word(24'h8)) begin errors++; $display("FAIL pop2_data got %h exp %h", instr_data, flash_word(24'h8)); end
  endtask

  task automatic test_branch_flush_wrap;
    int base;
    wait_until(LAT + 80);
    branch_valid = 1'b1;
    branch_addr = 24'hFFFFFE;
    instr_ready = 1'b1;
    tick(1);
    branch_valid = 1'b0;
    instr_ready = 1'b0;
    base = cyc;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", instr_valid); end
    checks++; if (spi_select !== 1'b1) begin errors++; $display("FAIL flush_sel got %b exp 1", spi_select); end
    wait_until(base + LAT - 5);
    checks++; if (cap_addr !== 24'hFFFFFC) begin errors++; $display("FAIL wrap_addr got %h exp fffffc", cap_addr); end
    wait_until(base + LAT);
    checks++; if (instr_pc !== 24'hFFFFFC) begin errors++; $display("FAIL wrap_pc0 got %h exp fffffc", instr_pc); end
    checks++; if (instr_data !== 32'hA5FFFFFC) begin errors++; $display("FAIL wrap_data0 got %h exp a5fffffc", instr_data); end
    wait_until(base + LAT + 33);
    instr_ready = 1'b1;
    tick(1);
    instr_ready = 1'b0;
    checks++; if (instr_pc !== 24'h000000) begin errors++; $display("FAIL wrap_pc1 got %h exp 000000", instr_pc); end
    checks++; if (instr_data !== 32'h00500093) begin errors++; $display("FAIL wrap_data1 got %h exp 00500093", instr_data); end
  endtask

  task automatic test_reset_mid;
    tick(10);
    rstn = 1'b0;
    #1;
    checks++; if ({spi_select, spi_clk_en, spi_out} !== 3'b100) begin errors++; $display("FAIL midrst_pins got %b exp 100", {spi_select, spi_clk_en, spi_out}); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", instr_valid); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    cyc = 0;
    wait_until(2);
    checks++; if (spi_select !== 1'b0) begin errors++; $display("FAIL restart_sel got %b exp 0", spi_select); end
    wait_until(LAT);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL restart_valid got %b exp 1", instr_valid); end
    checks++; if (instr_pc !== 24'h000000) begin errors++; $display("FAIL restart_pc got %h exp 000000", instr_pc); end
    checks++; if (instr_data !== 32'h00500093) begin errors++; $display("FAIL restart_data got %h exp 00500093", instr_data); end
  endtask

  task automatic test_branch_addr;
    apply_reset();
    wait_until(15);
    branch_valid = 1'b1;
    branch_addr = 24'h001237;
    tick(1);
    branch_valid = 1'b0;
    checks++; if ({spi_select, spi_clk_en} !== 2'b10) begin errors++; $display("FAIL br_c16_pins got %b exp 10", {spi_select, spi_clk_en}); end
    wait_until(17);
    checks++; if (spi_select !== 1'b1) begin errors++; $display("FAIL br_c17_sel got %b exp 1", spi_select); end
    wait_until(18);
    checks++; if (spi_select !== 1'b0) begin errors++; $display("FAIL br_c18_sel got %b exp 0", spi_select); end
    wait_until(55);
    checks++; if (cap_addr !== 24'h001234) begin errors++; $display("FAIL br_addr got %h exp 001234", cap_addr); end
    wait_until(16 + LAT);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL br_valid got %b exp 1", instr_valid); end
    checks++; if (instr_pc !== 24'h001234) begin errors++; $display("FAIL br_pc got %h exp 001234", instr_pc); end
    checks++; if (instr_data !== 32'hA5001234) begin errors++; $display("FAIL br_data got %h exp a5001234", instr_data); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_branch_flush_wrap();
    test_reset_mid();
    test_branch_addr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
